ps2_game_input: RTL and testbench

- Converts the PS/2 keyboard byte stream into the three game-control levels the processor reads through regfile $1–$3: move_left, move_right and game_status.
- It is the producer side of those processor inputs. It sits between the PS/2 byte receiver and the processor top, in the fast `clock` domain.
- Outputs are levels, stretched so that the div-4 processor clock always samples a key tap.

---
 rtl/ps2_game_pkg.sv | 33 +++
 rtl/ps2_game_input_hold_stretch.sv | 45 ++++
 rtl/ps2_game_input.sv | 125 ++++++++++++
 tb/tb_ps2_game_input.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_game_pkg.sv
// Shared scan-code constants and decoder state type for the PS/2 game-control block.
package ps2_game_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_IGN_ACK    = 8'hFA;
  localparam logic [7:0] SC_IGN_BAT    = 8'hAA;
  localparam logic [7:0] SC_IGN_ECHO   = 8'hEE;
  localparam logic [7:0] SC_IGN_RESEND = 8'hFE;
  localparam logic [7:0] SC_IGN_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

  // Keyboard housekeeping bytes that never start or finish a key sequence.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_IGN_ACK)    || (code == SC_IGN_BAT)    ||
           (code == SC_IGN_ECHO)   || (code == SC_IGN_RESEND) ||
           (code == SC_IGN_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_game_input_hold_stretch.sv
// Turns make/break pulses into a key level guaranteed to stay high for MIN_HOLD cycles.
module hold_stretch #(
  parameter int MIN_HOLD = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic make_i,
  input  logic brk_i,
  output logic level_o
);

  localparam int HW = $clog2(MIN_HOLD);

  logic          key_down_q, key_down_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q;

  always_comb begin
    key_down_d = key_down_q;
    hold_d     = (hold_q != '0) ? hold_q - HW'(1) : '0;
    if (make_i) begin
      key_down_d = 1'b1;
      hold_d     = HW'(MIN_HOLD - 1);
    end else if (brk_i) begin
      key_down_d = 1'b0;
    end
  end

  // The make cycle itself is covered by key_down_d; the old hold value covers the
  // following MIN_HOLD-1 cycles, so a make followed at once by a break still spans MIN_HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_down_q <= 1'b0;
      hold_q     <= '0;
      level_q    <= 1'b0;
    end else begin
      key_down_q <= key_down_d;
      hold_q     <= hold_d;
      level_q    <= key_down_d | (hold_q != '0);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_game_input.sv
// Decodes the PS/2 scan-code byte stream into move_left/move_right/game_status levels.
module ps2_game_input
  import ps2_game_pkg::*;
#(
  parameter int MIN_HOLD       = 8,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       move_left,
  output logic       move_right,
  output logic       game_status,
  output logic [7:0] last_code
);

  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;

  dec_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       pressed_q;
  logic       status_q, status_d;
  logic [7:0] last_q, last_d;
  logic       byte_evt;
  logic       key_done, key_ext, key_brk;
  logic       make_l, brk_l, make_r, brk_r;
  logic       is_l, is_r;

  assign byte_evt = ps2_key_pressed & ~pressed_q;

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    key_done = 1'b0;
    key_ext  = 1'b0;
    key_brk  = 1'b0;
    if (byte_evt) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_out == SC_EXT)      state_d = ST_EXT;
          else if (ps2_out == SC_BRK) state_d = ST_BRK;
          else if (!is_ignored(ps2_out)) key_done = 1'b1;
        end
        ST_EXT: begin
          if (ps2_out == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d  = ST_IDLE;
            key_done = 1'b1;
            key_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          key_done = 1'b1;
          key_brk  = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d  = ST_IDLE;
          key_done = 1'b1;
          key_ext  = 1'b1;
          key_brk  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A lost byte after a prefix must not leave the decoder stuck half-way.
      if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) state_d = ST_IDLE;
      else                                  tmo_d   = tmo_q + TW'(1);
    end
  end

  always_comb begin
    is_l     = key_ext ? (ps2_out == SC_LEFT)  : (ps2_out == SC_A);
    is_r     = key_ext ? (ps2_out == SC_RIGHT) : (ps2_out == SC_D);
    make_l   = key_done & ~key_brk & is_l;
    brk_l    = key_done &  key_brk & is_l;
    make_r   = key_done & ~key_brk & is_r;
    brk_r    = key_done &  key_brk & is_r;
    status_d = status_q;
    last_d   = last_q;
    if (key_done && !key_ext && !key_brk && ps2_out == SC_SPACE) status_d = 1'b1;
    if (key_done && !key_ext && !key_brk && ps2_out == SC_ESC)   status_d = 1'b0;
    if (key_done && (is_l || is_r ||
        (!key_ext && (ps2_out == SC_SPACE || ps2_out == SC_ESC))))
      last_d = ps2_out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      pressed_q <= 1'b0;
      status_q  <= 1'b0;
      last_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      pressed_q <= ps2_key_pressed;
      status_q  <= status_d;
      last_q    <= last_d;
    end
  end

  hold_stretch #(.MIN_HOLD(MIN_HOLD)) u_hold_left (
    .clock   (clock),
    .reset   (reset),
    .make_i  (make_l),
    .brk_i   (brk_l),
    .level_o (move_left)
  );

  hold_stretch #(.MIN_HOLD(MIN_HOLD)) u_hold_right (
    .clock   (clock),
    .reset   (reset),
    .make_i  (make_r),
    .brk_i   (brk_r),
    .level_o (move_right)
  );

  assign game_status = status_q;
  assign last_code   = last_q;

endmodule

// File: tb/tb_ps2_game_input.sv
// Directed bench for ps2_game_input: key decoding, hold stretching, status and prefix timeout.
module tb_ps2_game_input;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_out = 8'h00;
  logic       move_left, move_right, game_status;
  logic [7:0] last_code;

  int checks = 0;
  int errors = 0;

  ps2_game_input #(.MIN_HOLD(8), .PREFIX_TIMEOUT(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out),
    .move_left       (move_left),
    .move_right      (move_right),
    .game_status     (game_status),
    .last_code       (last_code)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_out = b;
    ps2_key_pressed = 1'b1;
    tick(1);
    ps2_key_pressed = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({move_left, move_right, game_status, last_code} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b %h want 000 00", move_left, move_right, game_status, last_code);
    end
    reset = 1'b1;
    tick(1);
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'hE1);
    checks++;
    if ({move_left, move_right, game_status, last_code} !== 11'h000) begin
      errors++;
      $display("FAIL ignored_bytes got %b%b%b %h want 000 00", move_left, move_right, game_status, last_code);
    end
    send_byte(8'h1C);
    checks++;
    if (move_left !== 1'b1 || last_code !== 8'h1C) begin
      errors++;
      $display("FAIL idle_after_ignored got left=%b code=%h want 1 1c", move_left, last_code);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    tick(10);
    checks++;
    if (move_left !== 1'b0) begin
      errors++;
      $display("FAIL a_release got left=%b want 0", move_left);
    end
    $display("txn reset/ignored done");
  endtask

  task automatic test_arrow_hold;
    int lcnt;
    int rcnt;
    send_byte(8'hE0);
    ps2_out = 8'h6B;
    ps2_key_pressed = 1'b1;
    #3;
    checks++;
    if (move_left !== 1'b0) begin
      errors++;
      $display("FAIL arrow_pre_edge got left=%b want 0", move_left);
    end
    @(posedge clock);
    #1;
    checks++;
    if (move_left !== 1'b1) begin
      errors++;
      $display("FAIL arrow_latency got left=%b want 1", move_left);
    end
    ps2_key_pressed = 1'b0;
    lcnt = 0;
    rcnt = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clock);
          if (move_left)  lcnt++;
          if (move_right) rcnt++;
        end
      end
      begin
        tick(1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
      end
    join
    checks++;
    if (lcnt !== 8) begin
      errors++;
      $display("FAIL arrow_hold_len got %0d cycles want 8", lcnt);
    end
    checks++;
    if (rcnt !== 0 || move_left !== 1'b0 || last_code !== 8'h6B) begin
      errors++;
      $display("FAIL arrow_after got right_cycles=%0d left=%b code=%h want 0 0 6b", rcnt, move_left, last_code);
    end
    $display("txn arrow make/hold: left high %0d cycles", lcnt);
  endtask

  task automatic test_both_dirs;
    send_byte(8'h23);
    checks++;
    if (move_right !== 1'b1 || move_left !== 1'b0) begin
      errors++;
      $display("FAIL d_make got l=%b r=%b want 0 1", move_left, move_right);
    end
    send_byte(8'h1C);
    checks++;
    if (move_right !== 1'b1 || move_left !== 1'b1) begin
      errors++;
      $display("FAIL both_held got l=%b r=%b want 1 1", move_left, move_right);
    end
    send_byte(8'hF0);
    send_byte(8'h23);
    tick(10);
    checks++;
    if (move_right !== 1'b0 || move_left !== 1'b1 || last_code !== 8'h23) begin
      errors++;
      $display("FAIL d_release got l=%b r=%b code=%h want 1 0 23", move_left, move_right, last_code);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    tick(10);
    checks++;
    if (move_left !== 1'b0 || last_code !== 8'h1C) begin
      errors++;
      $display("FAIL a_release2 got l=%b code=%h want 0 1c", move_left, last_code);
    end
    $display("txn both directions done");
  endtask

  task automatic test_start_stop;
    send_byte(8'h29);
    checks++;
    if (game_status !== 1'b1 || last_code !== 8'h29) begin
      errors++;
      $display("FAIL space_make got gs=%b code=%h want 1 29", game_status, last_code);
    end
    send_byte(8'hF0);
    send_byte(8'h29);
    checks++;
    if (game_status !== 1'b1) begin
      errors++;
      $display("FAIL space_break got gs=%b want 1", game_status);
    end
    send_byte(8'h76);
    checks++;
    if (game_status !== 1'b0 || last_code !== 8'h76) begin
      errors++;
      $display("FAIL esc_make got gs=%b code=%h want 0 76", game_status, last_code);
    end
    send_byte(8'h76);
    checks++;
    if (game_status !== 1'b0) begin
      errors++;
      $display("FAIL esc_again got gs=%b want 0", game_status);
    end
    $display("txn start/stop done");
  endtask

  task automatic test_prefix_timeout;
    send_byte(8'hE0);
    tick(16);
    send_byte(8'h74);
    checks++;
    if (move_right !== 1'b0 || last_code !== 8'h76) begin
      errors++;
      $display("FAIL timeout_plain74 got r=%b code=%h want 0 76", move_right, last_code);
    end
    send_byte(8'hE0);
    tick(3);
    send_byte(8'h74);
    checks++;
    if (move_right !== 1'b1 || last_code !== 8'h74) begin
      errors++;
      $display("FAIL no_timeout_ext74 got r=%b code=%h want 1 74", move_right, last_code);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    tick(10);
    checks++;
    if (move_right !== 1'b0) begin
      errors++;
      $display("FAIL ext74_release got r=%b want 0", move_right);
    end
    $display("txn prefix timeout done");
  endtask

  task automatic test_midseq_reset;
    send_byte(8'h29);
    send_byte(8'hE0);
    reset = 1'b0;
    #1;
    checks++;
    if (game_status !== 1'b0 || last_code !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got gs=%b code=%h want 0 00", game_status, last_code);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    ps2_out = 8'h6B;
    ps2_key_pressed = 1'b1;
    tick(5);
    ps2_key_pressed = 1'b0;
    tick(2);
    checks++;
    if (move_left !== 1'b0 || last_code !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_6b got l=%b code=%h want 0 00", move_left, last_code);
    end
    send_byte(8'hF0);
    ps2_out = 8'h1C;
    ps2_key_pressed = 1'b1;
    tick(5);
    ps2_key_pressed = 1'b0;
    tick(2);
    checks++;
    if (move_left !== 1'b0 || last_code !== 8'h1C) begin
      errors++;
      $display("FAIL long_strobe_once got l=%b code=%h want 0 1c", move_left, last_code);
    end
    $display("txn mid-sequence reset / strobe width done");
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_arrow_hold();
    test_both_dirs();
    test_start_stop();
    test_prefix_timeout();
    test_midseq_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
